// File: rtl/memory_access_pkg.sv
// Shared access codes, FSM states and alignment helpers
// for the data memory responder.
package memory_access_pkg;

    localparam logic [2:0] ACC_WR_BYTE = 3'd1;
    localparam logic [2:0] ACC_WR_WORD = 3'd2;
    localparam logic [2:0] ACC_WR_HALF = 3'd3;
    localparam logic [2:0] ACC_RD_BYTE = 3'd4;
    localparam logic [2:0] ACC_RD_HALF = 3'd5;
    localparam logic [2:0] ACC_RD_WORD = 3'd6;

    localparam int LANES = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    // Illegal codes and misaligned halfword/word accesses fault.
    function automatic logic access_fault(
        input logic [2:0] code,
        input logic [1:0] alo
    );
        case (code)
            ACC_WR_BYTE, ACC_RD_BYTE: return 1'b0;
            ACC_WR_HALF, ACC_RD_HALF: return alo[0];
            ACC_WR_WORD, ACC_RD_WORD: return |alo;
            default:                  return 1'b1;
        endcase
    endfunction

    function automatic logic is_read(input logic [2:0] code);
        return (code == ACC_RD_BYTE) || (code == ACC_RD_HALF) ||
               (code == ACC_RD_WORD);
    endfunction

    function automatic logic is_write(input logic [2:0] code);
        return (code == ACC_WR_BYTE) || (code == ACC_WR_HALF) ||
               (code == ACC_WR_WORD);
    endfunction

endpackage

// File: rtl/byte_bank.sv
// One 8-bit byte lane of the data RAM: single port,
// synchronous write and synchronous read.
module byte_bank #(
    parameter int AW = 10
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic          i_re,
    input  logic [AW-1:0] i_addr,
    input  logic [7:0]    i_wdata,
    output logic [7:0]    o_rdata
);

    localparam int DEPTH = 1 << AW;

    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_dout;

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
        if (i_re) r_dout <= r_mem[i_addr];
    end

    assign o_rdata = r_dout;

endmodule

// File: rtl/data_memory_responder.sv
// Byte-lane steering data memory with a valid/ready
// request/response handshake.
module data_memory_responder
    import memory_access_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_control,
    input  logic [ADDR_WIDTH-1:0] req_address,
    input  logic [7:0]            wr_byte3,
    input  logic [7:0]            wr_byte2,
    input  logic [7:0]            wr_byte1,
    input  logic [7:0]            wr_byte0,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           read_data,
    output logic                  fault
);

    localparam int WAW = ADDR_WIDTH - 2;

    state_t r_state;
    state_t w_next;

    logic [2:0]       r_ctrl;
    logic [1:0]       r_alo;
    logic [31:0]      r_rdata;
    logic             r_fault;
    logic [7:0]       w_lane  [LANES];
    logic [7:0]       w_wdata [LANES];
    logic [7:0]       w_dout  [LANES];
    logic [LANES-1:0] w_we;
    logic             w_re;
    logic             w_accept;
    logic             w_fault;
    logic [31:0]      w_steer;

    assign w_lane[0] = wr_byte0;
    assign w_lane[1] = wr_byte1;
    assign w_lane[2] = wr_byte2;
    assign w_lane[3] = wr_byte3;

    assign w_accept = req_valid && (r_state == IDLE);
    assign w_fault  = access_fault(req_control, req_address[1:0]);
    // Reads sample the RAM on the accepting edge; ACCESS registers the result.
    assign w_re     = w_accept && !w_fault && is_read(req_control);

    always_comb begin
        w_we = '0;
        for (int k = 0; k < LANES; k++) w_wdata[k] = w_lane[k];
        case (req_control)
            ACC_WR_BYTE: begin
                for (int k = 0; k < LANES; k++) w_wdata[k] = w_lane[0];
                w_we[req_address[1:0]] = 1'b1;
            end
            ACC_WR_HALF: begin
                w_wdata[2] = w_lane[0];
                w_wdata[3] = w_lane[1];
                w_we = req_address[1] ? 4'b1100 : 4'b0011;
            end
            default: w_we = 4'b1111;
        endcase
        if (!(w_accept && !w_fault && is_write(req_control))) w_we = '0;
    end

    always_comb begin
        case (r_ctrl)
            ACC_RD_BYTE: w_steer = {24'h0, w_dout[r_alo]};
            ACC_RD_HALF: w_steer = r_alo[1] ?
                {16'h0, w_dout[3], w_dout[2]} :
                {16'h0, w_dout[1], w_dout[0]};
            default:     w_steer = {w_dout[3], w_dout[2],
                                    w_dout[1], w_dout[0]};
        endcase
    end

    for (genvar k = 0; k < LANES; k++) begin : g_bank
        byte_bank #(
            .AW(WAW)
        ) u_bank (
            .i_clk  (clock),
            .i_we   (w_we[k]),
            .i_re   (w_re),
            .i_addr (req_address[ADDR_WIDTH-1:2]),
            .i_wdata(w_wdata[k]),
            .o_rdata(w_dout[k])
        );
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = (is_read(req_control) && !w_fault) ?
                             ACCESS : RESP;
                end
            end
            ACCESS: w_next = RESP;
            RESP:   if (resp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ctrl  <= 3'd0;
            r_alo   <= 2'd0;
            r_rdata <= 32'h0;
            r_fault <= 1'b0;
        end else if (w_accept) begin
            r_ctrl  <= req_control;
            r_alo   <= req_address[1:0];
            r_rdata <= 32'h0;
            r_fault <= w_fault;
        end else if (r_state == ACCESS) begin
            r_rdata <= w_steer;
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = (r_state == RESP);
    assign read_data  = r_rdata;
    assign fault      = r_fault;

endmodule
